// File: rtl/quad_encoder_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// quad_encoder_array : NUM_CH filtered quadrature decoders with capture/readout
// Optional macro QENC_SATURATE_EN makes counters saturate instead of wrap.
// Revision 1.0
// ---------------------------------------------------------------------------
module quad_encoder_array #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int SEL_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_a,
  input  logic [NUM_CH-1:0] in_b,
  input  logic [NUM_CH-1:0] clr,
  input  logic              capture,
  input  logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  rd_val,
  output logic [NUM_CH-1:0] err,
  input  logic              err_clr
);

  localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILT_LEN - 1);
`ifdef QENC_SATURATE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
`endif

  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] rd_val_q, rd_val_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    // Phase pairs are packed as {a, b}.
    logic [1:0] s1_q, s1_d, s2_q, s2_d, samp_q, samp_d;
    logic [1:0] filt_q, filt_d, prev_q, prev_d;
    logic [1:0][FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
    logic err_q, err_d;
    logic [1:0] chg;
    logic illegal, step_up, step_dn;

    assign chg     = filt_q ^ prev_q;
    assign illegal = &chg;
    // Forward direction is identified by old A differing from new B.
    assign step_up = (^chg) & (prev_q[1] ^ filt_q[0]);
    assign step_dn = (^chg) & ~(prev_q[1] ^ filt_q[0]);

    always_comb begin
      s1_d     = {in_a[ch], in_b[ch]};
      s2_d     = s1_q;
      samp_d   = s2_q;
      fcnt_d   = fcnt_q;
      filt_d   = filt_q;
      prev_d   = filt_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      shadow_d = capture ? cnt_q : shadow_q;

      for (int p = 0; p < 2; p++) begin
        if (s2_q[p] == samp_q[p]) begin
          if (fcnt_q[p] != FCNT_MAX) fcnt_d[p] = fcnt_q[p] + 1'b1;
        end else begin
          fcnt_d[p] = '0;
        end
        if (fcnt_d[p] == FCNT_MAX) filt_d[p] = s2_q[p];
      end

      if (step_up) begin
`ifdef QENC_SATURATE_EN
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`else
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end else if (step_dn) begin
`ifdef QENC_SATURATE_EN
        if (cnt_q != CNT_MIN) cnt_d = cnt_q - CNT_W'(1);
`else
        cnt_d = cnt_q - CNT_W'(1);
`endif
      end

      if (err_clr) err_d = 1'b0;
      if (illegal) err_d = 1'b1;

      // Reloading filter and decode history from the current sample keeps
      // the clear itself from producing a step on the next cycle.
      if (clr[ch]) begin
        cnt_d  = '0;
        err_d  = 1'b0;
        samp_d = s2_q;
        fcnt_d = '0;
        filt_d = s2_q;
        prev_d = s2_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q     <= '0;
        s2_q     <= '0;
        samp_q   <= '0;
        fcnt_q   <= '0;
        filt_q   <= '0;
        prev_q   <= '0;
        cnt_q    <= '0;
        err_q    <= 1'b0;
        shadow_q <= '0;
      end else begin
        s1_q     <= s1_d;
        s2_q     <= s2_d;
        samp_q   <= samp_d;
        fcnt_q   <= fcnt_d;
        filt_q   <= filt_d;
        prev_q   <= prev_d;
        cnt_q    <= cnt_d;
        err_q    <= err_d;
        shadow_q <= shadow_d;
      end
    end

    assign shadow[ch] = shadow_q;
    assign err[ch]    = err_q;
  end

  always_comb begin
    rd_val_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel) == i) rd_val_d = shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_val_q <= '0;
    else     rd_val_q <= rd_val_d;
  end

  assign rd_val = rd_val_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_quad_encoder_array : directed scoreboard bench for quad_encoder_array
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_quad_encoder_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  in_a, in_b, clr, err;
  logic        capture, err_clr, sel;
  logic [15:0] rd_val;

  logic        in_a4, in_b4, clr4, capture4, sel4, err4, err_clr4;
  logic [3:0]  rd_val4;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [1:0]  st [2];
  logic [1:0]  st4;

`ifdef QENC_SATURATE_EN
  localparam logic [3:0] OVF_UP = 4'h7;
  localparam logic [3:0] OVF_DN = 4'h8;
`else
  localparam logic [3:0] OVF_UP = 4'h8;
  localparam logic [3:0] OVF_DN = 4'h7;
`endif

  quad_encoder_array #(.NUM_CH(2), .CNT_W(16), .FILT_LEN(4), .SEL_W(1)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .clr(clr),
    .capture(capture), .sel(sel), .rd_val(rd_val), .err(err), .err_clr(err_clr)
  );

  quad_encoder_array #(.NUM_CH(1), .CNT_W(4), .FILT_LEN(1), .SEL_W(1)) dut4 (
    .clk(clk), .rst(rst), .in_a(in_a4), .in_b(in_b4), .clr(clr4),
    .capture(capture4), .sel(sel4), .rd_val(rd_val4), .err(err4), .err_clr(err_clr4)
  );

  function automatic logic [1:0] gray(input logic [1:0] s);
    case (s)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_phase(input int ch, input logic [1:0] g);
    in_a[ch] = g[1];
    in_b[ch] = g[0];
  endtask

  task automatic move(input int ch, input int dir, input int n, input int hold);
    logic [1:0] g;
    for (int i = 0; i < n; i++) begin
      st[ch] = st[ch] + 2'(dir);
      g = gray(st[ch]);
      set_phase(ch, g);
      tick(hold);
    end
  endtask

  task automatic move4(input int dir, input int n);
    logic [1:0] g;
    for (int i = 0; i < n; i++) begin
      st4 = st4 + 2'(dir);
      g = gray(st4);
      in_a4 = g[1];
      in_b4 = g[0];
      tick(8);
    end
  endtask

  task automatic cap_read(input logic s, input logic [31:0] expv, input string tag);
    sel = s;
    capture = 1'b1;
    exp_q.push_back(expv);
    tick(1);
    capture = 1'b0;
    tick(1);
    chk(tag, {16'h0, rd_val}, exp_q.pop_front());
  endtask

  task automatic cap_read4(input logic s, input logic [31:0] expv, input string tag);
    sel4 = s;
    capture4 = 1'b1;
    exp_q.push_back(expv);
    tick(1);
    capture4 = 1'b0;
    tick(1);
    chk(tag, {28'h0, rd_val4}, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; in_a = '0; in_b = '0; clr = '0; capture = 1'b0; err_clr = 1'b0; sel = 1'b0;
    in_a4 = 1'b0; in_b4 = 1'b0; clr4 = 1'b0; capture4 = 1'b0; sel4 = 1'b0; err_clr4 = 1'b0;
    st[0] = 2'd0; st[1] = 2'd0; st4 = 2'd0;
    tick(2);
    rst = 1'b0;
    chk("reset_rd_val", {16'h0, rd_val}, 32'h0);
    chk("reset_err", {30'h0, err}, 32'h0);
    cap_read(1'b0, 32'd0, "reset_cap_ch0");

    // Forward then reverse counting on channel 0
    move(0, 1, 8, 16);
    cap_read(1'b0, 32'd8, "fwd8_ch0");
    cap_read(1'b1, 32'd0, "fwd8_ch1");
    move(0, -1, 3, 16);
    cap_read(1'b0, 32'd5, "rev3_ch0");
    cap_read(1'b1, 32'd0, "rev3_ch1");

    // Three-cycle glitch on channel 1 A phase must be rejected
    in_a[1] = 1'b1;
    tick(3);
    in_a[1] = 1'b0;
    tick(16);
    cap_read(1'b1, 32'd0, "glitch_cnt");
    chk("glitch_err", {31'h0, err[1]}, 32'h0);

    // Exact latency: change sampled first at edge k, count moves at edge k+6
    st[1] = 2'd1;
    set_phase(1, gray(st[1]));
    tick(6);
    sel = 1'b1;
    capture = 1'b1;
    exp_q.push_back(32'd0);
    tick(1);
    exp_q.push_back(32'd1);
    tick(1);
    chk("latency_before", {16'h0, rd_val}, exp_q.pop_front());
    capture = 1'b0;
    tick(1);
    chk("latency_after", {16'h0, rd_val}, exp_q.pop_front());

    // Illegal transitions on channel 0 (bring it to 00 first)
    move(0, -1, 1, 16);
    st[0] = 2'd2;
    set_phase(0, 2'b11);
    tick(16);
    chk("illegal_err", {30'h0, err}, 32'h1);
    cap_read(1'b0, 32'd4, "illegal_cnt");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("errclr_alone", {30'h0, err}, 32'h0);
    st[0] = 2'd0;
    set_phase(0, 2'b00);
    tick(6);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("errclr_vs_set", {30'h0, err}, 32'h1);
    tick(8);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("errclr_final", {30'h0, err}, 32'h0);
    cap_read(1'b0, 32'd4, "illegal2_cnt");

    // Clear and capture in the same cycle on channel 1
    move(1, 1, 19, 16);
    cap_read(1'b1, 32'd20, "ch1_at_20");
    sel = 1'b1;
    clr[1] = 1'b1;
    capture = 1'b1;
    exp_q.push_back(32'd20);
    tick(1);
    clr[1] = 1'b0;
    capture = 1'b0;
    tick(1);
    chk("clr_cap_shadow", {16'h0, rd_val}, exp_q.pop_front());
    cap_read(1'b1, 32'd0, "after_clr");
    cap_read(1'b0, 32'd4, "ch0_untouched");
    move(1, 1, 1, 16);
    cap_read(1'b1, 32'd1, "step_after_clr");

    // Overflow behaviour on the narrow instance
    move4(1, 7);
    cap_read4(1'b0, 32'h7, "ovf_at_max");
    move4(1, 1);
    cap_read4(1'b0, {28'h0, OVF_UP}, "ovf_up");
    clr4 = 1'b1;
    tick(1);
    clr4 = 1'b0;
    tick(2);
    move4(-1, 8);
    cap_read4(1'b0, 32'h8, "ovf_at_min");
    move4(-1, 1);
    cap_read4(1'b0, {28'h0, OVF_DN}, "ovf_dn");
    cap_read4(1'b1, 32'h0, "sel_out_of_range");
    chk("ovf_no_err", {31'h0, err4}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
